i2s_receiver: RTL

Receive-side counterpart of the audio I2S transmitter. Samples an external Philips-format I2S stream (SCLK, LRCLK, SD) in the MCLK domain and reassembles left/right words. Presents one stereo frame per LRCLK period to a consumer through a valid/ready holding register. Used for audio loopback checking and for capturing ADC/codec input into the game audio path.

---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_rx_sync.sv | 50 +++++
 rtl/i2s_receiver.sv | 128 ++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: channel-state enum and default channel word width,
// common to the I2S transmitter and receiver.
package i2s_pkg;

  localparam int unsigned I2S_WIDTH     = 16;
  localparam int unsigned I2S_OVF_CNT_W = 16;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_t;

endpackage

// File: rtl/i2s_rx_sync.sv
// Brings SCLK/LRCLK/SD into the MCLK domain and produces a registered one-cycle
// tick per SCLK rising edge, with LRCLK/SD delayed to line up with that tick.
module i2s_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sclk,
  input  logic i_lrclk,
  input  logic i_sd,
  output logic o_tick,
  output logic o_lrclk,
  output logic o_sd
);

  logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
  logic r_lr_meta, r_lr_sync;
  logic r_sd_meta, r_sd_sync;
  logic r_tick, r_lr, r_sd;

  // Two-flop synchronizers, then a registered edge detect with aligned data
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclk_meta <= 1'b0;
      r_sclk_sync <= 1'b0;
      r_sclk_prev <= 1'b0;
      r_lr_meta   <= 1'b0;
      r_lr_sync   <= 1'b0;
      r_sd_meta   <= 1'b0;
      r_sd_sync   <= 1'b0;
      r_tick      <= 1'b0;
      r_lr        <= 1'b0;
      r_sd        <= 1'b0;
    end else begin
      r_sclk_meta <= i_sclk;
      r_sclk_sync <= r_sclk_meta;
      r_sclk_prev <= r_sclk_sync;
      r_lr_meta   <= i_lrclk;
      r_lr_sync   <= r_lr_meta;
      r_sd_meta   <= i_sd;
      r_sd_sync   <= r_sd_meta;
      r_tick      <= r_sclk_sync & ~r_sclk_prev;
      r_lr        <= r_lr_sync;
      r_sd        <= r_sd_sync;
    end
  end

  assign o_tick  = r_tick;
  assign o_lrclk = r_lr;
  assign o_sd    = r_sd;

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S receiver: reassembles left/right words into a valid/ready frame register.
// Optional saturating overflow counter enabled by defining I2S_RX_OVERFLOW_CNT_EN.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH = I2S_WIDTH
) (
  input  logic                     MCLK,
  input  logic                     Reset,
  input  logic                     onOff,
  input  logic                     SCLK,
  input  logic                     LRCLK,
  input  logic                     SD,
  input  logic                     Ready,
  output logic [2*WIDTH-1:0]       Rx,
  output logic                     Valid,
  output logic                     Overflow,
  output logic [I2S_OVF_CNT_W-1:0] OverflowCount
);

  localparam int unsigned IDX_W = $clog2(WIDTH + 1);

  logic             w_tick, w_lr, w_sd, w_change;
  logic             w_latch_left, w_load;
  i2s_state_t       r_state, w_state_next;
  logic             r_lr_prev;
  logic [IDX_W-1:0] r_bit_idx;
  logic [WIDTH-1:0] r_word, w_word_upd, r_left;

  i2s_rx_sync u_sync (
    .i_clk   (MCLK),
    .i_rst   (Reset),
    .i_sclk  (SCLK),
    .i_lrclk (LRCLK),
    .i_sd    (SD),
    .o_tick  (w_tick),
    .o_lrclk (w_lr),
    .o_sd    (w_sd)
  );

  assign w_change = w_tick && (w_lr != r_lr_prev);

  // Place the current SD bit at its MSB-first slot position; index == WIDTH drops it
  always_comb begin
    w_word_upd = r_word;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (r_bit_idx == IDX_W'(WIDTH - 1 - i)) w_word_upd[i] = w_sd;
    end
  end

  always_ff @(posedge MCLK) begin
    if (Reset) r_state <= ALIGN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_latch_left = 1'b0;
    w_load       = 1'b0;
    if (!onOff) begin
      w_state_next = ALIGN;
    end else if (w_change) begin
      case (r_state)
        ALIGN: if (!w_lr) w_state_next = LEFT;
        LEFT: if (w_lr) begin
          w_latch_left = 1'b1;
          w_state_next = RIGHT;
        end
        RIGHT: if (!w_lr) begin
          w_load       = 1'b1;
          w_state_next = LEFT;
        end
        default: w_state_next = ALIGN;
      endcase
    end
  end

  // Slot shifter, left-word latch and the consumer-facing holding register
  always_ff @(posedge MCLK) begin
    if (Reset) begin
      r_lr_prev <= 1'b0;
      r_bit_idx <= '0;
      r_word    <= '0;
      r_left    <= '0;
      Rx        <= '0;
      Valid     <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      Overflow <= 1'b0;
      if (w_tick) begin
        r_lr_prev <= w_lr;
        if (w_change) begin
          r_word    <= '0;
          r_bit_idx <= '0;
        end else begin
          r_word <= w_word_upd;
          if (r_bit_idx != IDX_W'(WIDTH)) r_bit_idx <= r_bit_idx + IDX_W'(1);
        end
      end
      if (w_latch_left) r_left <= w_word_upd;
      if (w_load) begin
        Rx       <= {r_left, w_word_upd};
        Valid    <= 1'b1;
        Overflow <= Valid && !Ready;
      end else if (Valid && Ready) begin
        Valid <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_OVERFLOW_CNT_EN
  logic [I2S_OVF_CNT_W-1:0] r_ovf_cnt;

  // Counts in the same cycle Overflow is raised; sticks at all-ones
  always_ff @(posedge MCLK) begin
    if (Reset) begin
      r_ovf_cnt <= '0;
    end else if (w_load && Valid && !Ready && (r_ovf_cnt != '1)) begin
      r_ovf_cnt <= r_ovf_cnt + I2S_OVF_CNT_W'(1);
    end
  end

  assign OverflowCount = r_ovf_cnt;
`else
  assign OverflowCount = '0;
`endif

endmodule
